// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: loader and receiver state
// encodings, error codes and UART frame shape.
package uart_program_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRxData,
    StRxCsum,
    StDone,
    StError
  } loader_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrCount = 2'b01;
  localparam logic [1:0] ErrFrame = 2'b10;
  localparam logic [1:0] ErrCsum  = 2'b11;

  localparam int unsigned UartDataBits = 8;
  localparam int unsigned UartStopBits = 1;

endpackage

// File: rtl/uart_program_loader_rx.sv
// UART 8N1 receiver.
// Ports: clk, reset (async, active-high), rx_i (raw serial line, idle high),
//        byte_o (received byte), byte_valid_o (1-cycle pulse on good stop bit),
//        frame_err_o (1-cycle pulse on low stop bit).
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] DataEnd = 3'(UartDataBits - 1);
  localparam logic [2:0] StopEnd = 3'(UartStopBits - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        // Mid-start re-check rejects glitches shorter than half a bit.
        if (cnt_q == HalfEnd) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == DataEnd) begin
            bit_cnt_d = '0;
            state_d   = RxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            ferr_d  = 1'b1;
            state_d = RxIdle;
          end else if (bit_cnt_q == StopEnd) begin
            valid_d = 1'b1;
            state_d = RxIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_comb begin
    byte_o       = shift_q;
    byte_valid_o = valid_q;
    frame_err_o  = ferr_q;
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a counted, XOR-checksummed program image over UART,
// writes it word by word into program memory and holds the core in reset
// until a valid image is stored.
// Ports: clk, reset (async, active-high), rx_i (serial in), reload_i (restart
//        from DONE/ERROR), core_reset_o, mem_we_o/mem_addr_o/mem_data_o (memory
//        write port, byte address), busy_o, done_o, error_o, error_code_o.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT         = 434,
  parameter int unsigned PROGRAM_MEMORY_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_i,
  input  logic        reload_i,
  output logic        core_reset_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  error_code_o
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, byte_ok;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  // A byte landing in the same cycle as reload is discarded.
  assign byte_ok = rx_valid & ~reload_i;

  loader_state_e state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_buf_q, word_buf_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic [1:0]    err_code_q, err_code_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      csum_q     <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    csum_d     = csum_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (rx_ferr) begin
          state_d    = StError;
          err_code_d = ErrFrame;
        end else if (byte_ok) begin
          if (rx_byte == 8'd0 || 32'(rx_byte) > PROGRAM_MEMORY_DEPTH) begin
            state_d    = StError;
            err_code_d = ErrCount;
          end else begin
            count_d    = rx_byte;
            csum_d     = rx_byte;
            word_idx_d = '0;
            byte_idx_d = '0;
            state_d    = StRxData;
          end
        end
      end
      StRxData: begin
        if (rx_ferr) begin
          state_d    = StError;
          err_code_d = ErrFrame;
        end else if (byte_ok) begin
          csum_d                         = csum_q ^ rx_byte;
          byte_idx_d                     = byte_idx_q + 2'd1;
          word_buf_d[8*byte_idx_q +: 8]  = rx_byte;
          if (byte_idx_q == 2'd3) begin
            // Write strobe is registered, so it appears the cycle after the
            // last byte of the word arrives.
            mem_we_d   = 1'b1;
            mem_addr_d = {22'd0, word_idx_q, 2'b00};
            mem_data_d = {rx_byte, word_buf_q[23:0]};
            word_idx_d = word_idx_q + 8'd1;
            if (word_idx_q == count_q - 8'd1) begin
              state_d = StRxCsum;
            end
          end
        end
      end
      StRxCsum: begin
        if (rx_ferr) begin
          state_d    = StError;
          err_code_d = ErrFrame;
        end else if (byte_ok) begin
          if (rx_byte == csum_q) begin
            state_d = StDone;
          end else begin
            state_d    = StError;
            err_code_d = ErrCsum;
          end
        end
      end
      StDone, StError: begin
        if (reload_i) begin
          state_d    = StIdle;
          err_code_d = ErrNone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_reset_o = (state_q != StDone);
    busy_o       = (state_q == StRxData) || (state_q == StRxCsum);
    done_o       = (state_q == StDone);
    error_o      = (state_q == StError);
    error_code_o = err_code_q;
    mem_we_o     = mem_we_q;
    mem_addr_o   = mem_addr_q;
    mem_data_o   = mem_data_q;
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a write scoreboard.
module tb_uart_program_loader;

  localparam int unsigned Cpb = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic        reload_i;
  logic        core_reset_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  error_code_o;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT        (Cpb),
    .PROGRAM_MEMORY_DEPTH(64)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .rx_i        (rx_i),
    .reload_i    (reload_i),
    .core_reset_o(core_reset_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .error_code_o(error_code_o)
  );

  int          checks    = 0;
  int          failures  = 0;
  int          we_count  = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  img[$];
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst === 1'b0 && mem_we_o === 1'b1) begin
      we_count++;
      check("write_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", mem_addr_o, e[63:32]);
        check("write_data", mem_data_o, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx_i = stop;
    repeat (Cpb) @(negedge clk);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Image = count, words little-endian, XOR of all preceding bytes.
  task automatic build_image();
    logic [7:0] c;
    img.delete();
    img.push_back(8'(words.size()));
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) img.push_back(words[i][8*k +: 8]);
    end
    c = 8'h00;
    foreach (img[i]) c = c ^ img[i];
    img.push_back(c);
  endtask

  task automatic send_image(input int n_bytes, input int bad_stop_idx, input bit expect_writes);
    for (int i = 0; i < n_bytes; i++) begin
      if (expect_writes && i >= 4 && (i % 4) == 0 && i <= 4 * words.size())
        exp_q.push_back({32'((i / 4 - 1) * 4), words[i/4-1]});
      send_byte(img[i], i != bad_stop_idx);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    we_count = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload_i = 1'b1;
    @(negedge clk);
    reload_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_reset"}, core_reset_o, 1);
    check({tag, "_we"}, mem_we_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_data"}, mem_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_error"}, error_o, 0);
    check({tag, "_code"}, error_code_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    rx_i = 1'b1;
    reload_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good two-word image.
    words = '{32'h0050_0013, 32'h00B5_05B3};
    build_image();
    we_count = 0;
    send_image(img.size(), -1, 1'b1);
    check("good_done", done_o, 1);
    check("good_core_reset", core_reset_o, 0);
    check("good_error", error_o, 0);
    check("good_busy", busy_o, 0);
    check("good_we_count", 32'(we_count), 2);
    check("good_sb_empty", 32'(exp_q.size()), 0);
    check("good_addr_hold", mem_addr_o, 32'h4);
    check("good_data_hold", mem_data_o, 32'h00B5_05B3);

    // Reload from DONE, then a second image.
    pulse_reload();
    check("reload_core_reset", core_reset_o, 1);
    check("reload_done", done_o, 0);
    words = '{32'hDEAD_BEEF};
    build_image();
    we_count = 0;
    send_image(img.size(), -1, 1'b1);
    check("second_done", done_o, 1);
    check("second_core_reset", core_reset_o, 0);
    check("second_we_count", 32'(we_count), 1);

    // Zero word count.
    pulse_reload();
    we_count = 0;
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("cnt0_error", error_o, 1);
    check("cnt0_code", error_code_o, 2'b01);
    check("cnt0_core_reset", core_reset_o, 1);
    check("cnt0_we_count", 32'(we_count), 0);

    // Reload from ERROR clears the error.
    pulse_reload();
    check("reload_err_error", error_o, 0);
    check("reload_err_code", error_code_o, 0);

    // Count above depth.
    do_reset();
    send_byte(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    check("cnt65_error", error_o, 1);
    check("cnt65_code", error_code_o, 2'b01);
    check("cnt65_we_count", 32'(we_count), 0);

    // Checksum mismatch: both words still land.
    do_reset();
    words = '{32'h0050_0013, 32'h00B5_05B3};
    build_image();
    img[img.size()-1] = 8'h08;
    send_image(img.size(), -1, 1'b1);
    check("csum_we_count", 32'(we_count), 2);
    check("csum_error", error_o, 1);
    check("csum_code", error_code_o, 2'b11);
    check("csum_core_reset", core_reset_o, 1);
    check("csum_done", done_o, 0);

    // Low stop bit on the third data byte.
    do_reset();
    build_image();
    send_image(img.size(), 3, 1'b0);
    check("frame_error", error_o, 1);
    check("frame_code", error_code_o, 2'b10);
    check("frame_we_count", 32'(we_count), 0);

    // One-cycle glitch is not a start bit.
    do_reset();
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy", busy_o, 0);
    check("glitch_error", error_o, 0);
    check("glitch_done", done_o, 0);
    check("glitch_core_reset", core_reset_o, 1);
    send_image(img.size(), -1, 1'b1);
    check("glitch_then_done", done_o, 1);
    check("glitch_then_we_count", 32'(we_count), 2);

    // Reset in the middle of RX_DATA.
    do_reset();
    send_image(5, -1, 1'b1);
    check("mid_we_count", 32'(we_count), 1);
    rx_i = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rx_i = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
